// File: rtl/hplvds_pkg.sv
// hplvds_pkg: shared state type and status encoding for the HPLVDS lane controller
package hplvds_pkg;
  typedef enum logic [1:0] {OFF = 2'd0, BIAS = 2'd1, IDLE = 2'd2, ACTIVE = 2'd3} laneState_t;
  function automatic logic [1:0] stateCode(laneState_t s);
    return s;
  endfunction
endpackage

// File: rtl/hplvds_lane_ctrl_if.sv
// hplvds_lane_ctrl_if: link-layer side of the HPLVDS lane controller
interface hplvds_lane_ctrl_if #(parameter int LANES = 4, SER_W = 8);
  logic EN_I, EI_REQ_I, TXD_VALID_I, TXD_READY_O, RXD_VALID_O, UNDERFLOW_O;
  logic [LANES*SER_W-1:0] TXD_I, RXD_O;
  logic [LANES-1:0] TX_POL_I, RX_POL_I, EI_DETECTED_O;
  logic [1:0] STATE_O;
  modport master(output EN_I, EI_REQ_I, TXD_I, TXD_VALID_I, TX_POL_I, RX_POL_I,
                 input TXD_READY_O, RXD_O, RXD_VALID_O, UNDERFLOW_O, STATE_O, EI_DETECTED_O);
  modport slave(input EN_I, EI_REQ_I, TXD_I, TXD_VALID_I, TX_POL_I, RX_POL_I,
                output TXD_READY_O, RXD_O, RXD_VALID_O, UNDERFLOW_O, STATE_O, EI_DETECTED_O);
endinterface

// File: rtl/hplvds_lane.sv
// hplvds_lane: one lane's TX serialiser, RX collector and EI-detect debouncer
module hplvds_lane #(parameter int SER_W = 8, EI_DEB = 4) (
  input logic clk,
  input logic rst,
  input logic active,
  input logic rxEn,
  input logic rxDone,
  input logic load,
  input logic txPol,
  input logic rxPol,
  input logic padDi,
  input logic detEn,
  input logic det,
  input logic [SER_W-1:0] loadWord,
  input logic [$clog2(SER_W)-1:0] bitIdx,
  output logic txBit,
  output logic eiDetected,
  output logic [SER_W-1:0] rxWord
);
  localparam int DW = $clog2(EI_DEB + 1);
  logic [SER_W-1:0] txShift, rxShift, rxNext;
  logic [DW-1:0] debCnt, debNext;
  always_comb begin
    rxNext = rxShift;
    rxNext[bitIdx] = padDi ^ rxPol;
    debNext = !(detEn && det) ? '0 : debCnt == DW'(EI_DEB) ? debCnt : debCnt + 1'b1;
    txBit = active & (txShift[0] ^ txPol);
  end
  always_ff @(posedge clk)
    if (rst) begin
      txShift <= '0;
      rxShift <= '0;
      rxWord <= '0;
      debCnt <= '0;
      eiDetected <= 1'b0;
    end else begin
      txShift <= load ? loadWord : active ? txShift >> 1 : '0;
      if (rxEn) rxShift <= rxNext;
      if (rxDone) rxWord <= rxNext;
      debCnt <= debNext;
      eiDetected <= debNext == DW'(EI_DEB);
    end
endmodule

// File: rtl/hplvds_lane_ctrl.sv
// hplvds_lane_ctrl: HPLVDS pad power sequencer, handshake and multi-lane serdes control
module hplvds_lane_ctrl
  import hplvds_pkg::*;
#(parameter int LANES = 4, SER_W = 8, BIAS_WAIT = 16, EI_DEB = 4) (
  input logic CLK_I,
  input logic RST_I,
  hplvds_lane_ctrl_if.slave link,
  output logic [LANES-1:0] PAD_DO_O,
  output logic PAD_TX_EN_O,
  output logic PAD_TX_VCM_EN_O,
  output logic PAD_TX_EI_O,
  output logic PAD_RTERM_EN_O,
  output logic PAD_EI_DET_EN_O,
  input logic [LANES-1:0] PAD_DI_I,
  input logic [LANES-1:0] PAD_EI_DET_I
);
  localparam int CW = $clog2(BIAS_WAIT > SER_W ? BIAS_WAIT : SER_W);
  localparam int IW = $clog2(SER_W);
  laneState_t state, nextState;
  logic [CW-1:0] cnt, nextCnt;
  logic firstCyc, eiPend, stop, slot, ready, active, rxEn, rxDone;
  always_comb begin
    nextState = state;
    nextCnt = cnt;
    active = state == ACTIVE;
    stop = link.EI_REQ_I || eiPend;
    slot = active && cnt == CW'(SER_W - 1);
    ready = slot && !stop && link.EN_I;
    rxEn = active && !firstCyc;
    rxDone = rxEn && slot && link.EN_I;
    if (!link.EN_I) begin
      nextState = OFF;
      nextCnt = '0;
    end else
      case (state)
        OFF: nextState = BIAS;
        BIAS: begin
          nextState = cnt == CW'(BIAS_WAIT - 1) ? IDLE : BIAS;
          nextCnt = cnt == CW'(BIAS_WAIT - 1) ? '0 : cnt + 1'b1;
        end
        IDLE: if (!link.EI_REQ_I) begin
          nextState = ACTIVE;
          nextCnt = CW'(SER_W - 1);
        end
        default: begin
          nextState = slot && stop ? IDLE : ACTIVE;
          nextCnt = slot ? '0 : cnt + 1'b1;
        end
      endcase
    PAD_TX_EN_O = state != OFF;
    PAD_TX_VCM_EN_O = state != OFF;
    PAD_RTERM_EN_O = state != OFF;
    PAD_TX_EI_O = state == BIAS || state == IDLE;
    PAD_EI_DET_EN_O = state == IDLE || state == ACTIVE;
    link.STATE_O = stateCode(state);
    link.TXD_READY_O = ready;
  end
  always_ff @(posedge CLK_I)
    if (RST_I) begin
      state <= OFF;
      cnt <= '0;
      firstCyc <= 1'b0;
      eiPend <= 1'b0;
      link.UNDERFLOW_O <= 1'b0;
      link.RXD_VALID_O <= 1'b0;
    end else begin
      state <= nextState;
      cnt <= nextCnt;
      firstCyc <= !active && nextState == ACTIVE;
      eiPend <= nextState == ACTIVE && stop;
      link.UNDERFLOW_O <= ready && !link.TXD_VALID_I;
      link.RXD_VALID_O <= rxDone;
    end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    hplvds_lane #(.SER_W(SER_W), .EI_DEB(EI_DEB)) u_lane (
      .clk(CLK_I),
      .rst(RST_I),
      .active(active),
      .rxEn(rxEn),
      .rxDone(rxDone),
      .load(ready),
      .txPol(link.TX_POL_I[l]),
      .rxPol(link.RX_POL_I[l]),
      .padDi(PAD_DI_I[l]),
      .detEn(PAD_EI_DET_EN_O),
      .det(PAD_EI_DET_I[l]),
      .loadWord(link.TXD_I[l*SER_W +: SER_W] & {SER_W{link.TXD_VALID_I}}),
      .bitIdx(cnt[IW-1:0]),
      .txBit(PAD_DO_O[l]),
      .eiDetected(link.EI_DETECTED_O[l]),
      .rxWord(link.RXD_O[l*SER_W +: SER_W])
    );
  end
endmodule

// File: tb/tb_hplvds_lane_ctrl.sv
// tb_hplvds_lane_ctrl: randomized bench for hplvds_lane_ctrl against a queue-based reference model
module tb_hplvds_lane_ctrl;
  localparam int LANES = 4, SER_W = 8, BIAS_WAIT = 16, EI_DEB = 4, LW = LANES * SER_W;
  localparam int M_OFF = 0, M_BIAS = 1, M_IDLE = 2, M_ACT = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic [LANES-1:0] padDo, padDi, padEiDet;
  logic padTxEn, padVcm, padTxEi, padRterm, padDetEn;
  hplvds_lane_ctrl_if #(.LANES(LANES), .SER_W(SER_W)) link();
  hplvds_lane_ctrl #(.LANES(LANES), .SER_W(SER_W), .BIAS_WAIT(BIAS_WAIT), .EI_DEB(EI_DEB)) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .link(link),
    .PAD_DO_O(padDo),
    .PAD_TX_EN_O(padTxEn),
    .PAD_TX_VCM_EN_O(padVcm),
    .PAD_TX_EI_O(padTxEi),
    .PAD_RTERM_EN_O(padRterm),
    .PAD_EI_DET_EN_O(padDetEn),
    .PAD_DI_I(padDi),
    .PAD_EI_DET_I(padEiDet)
  );
  always #5 clk = ~clk;
  int nTests = 0, nFail = 0;
  int mSt, biasCnt, debRun[LANES];
  bit eiPend, loop, expUnder, expRxValid;
  logic [LANES-1:0] txQ[$], rxQ[$], expDet;
  logic [LW-1:0] expRxd;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic resetModel();
    mSt = M_OFF;
    biasCnt = 0;
    eiPend = 0;
    expUnder = 0;
    expRxValid = 0;
    expRxd = '0;
    expDet = '0;
    txQ.delete();
    rxQ.delete();
    foreach (debRun[l]) debRun[l] = 0;
  endtask
  task automatic step();
    logic [LANES-1:0] fr, eDo, e;
    bit stop, slot, eRdy, en, detOn;
    @(negedge clk);
    en = link.EN_I;
    fr = txQ.size() > 0 ? txQ[0] : '0;
    eDo = mSt == M_ACT ? fr ^ link.TX_POL_I : '0;
    stop = link.EI_REQ_I || eiPend;
    slot = mSt == M_ACT && txQ.size() <= 1;
    eRdy = slot && !stop && en;
    if (loop) padDi = eDo;
    chk("state", link.STATE_O, mSt);
    chk("pads", {padTxEn, padVcm, padRterm, padTxEi, padDetEn},
        {mSt != M_OFF, mSt != M_OFF, mSt != M_OFF, mSt == M_BIAS || mSt == M_IDLE, mSt >= M_IDLE});
    chk("ready", link.TXD_READY_O, eRdy);
    chk("padDo", padDo, eDo);
    chk("underflow", link.UNDERFLOW_O, expUnder);
    chk("rxValid", link.RXD_VALID_O, expRxValid);
    chk("rxd", link.RXD_O, expRxd);
    chk("eiDet", link.EI_DETECTED_O, expDet);
    if (rst) resetModel();
    else begin
      detOn = mSt == M_IDLE || mSt == M_ACT;
      for (int l = 0; l < LANES; l++) begin
        debRun[l] = (detOn && padEiDet[l]) ? (debRun[l] < EI_DEB ? debRun[l] + 1 : EI_DEB) : 0;
        expDet[l] = debRun[l] == EI_DEB;
      end
      expUnder = eRdy && !link.TXD_VALID_I;
      expRxValid = 0;
      if (mSt == M_ACT && txQ.size() > 0) begin
        rxQ.push_back(padDi ^ link.RX_POL_I);
        void'(txQ.pop_front());
        if (rxQ.size() == SER_W && en) begin
          for (int j = 0; j < SER_W; j++)
            for (int l = 0; l < LANES; l++) expRxd[l*SER_W+j] = rxQ[j][l];
          expRxValid = 1;
          rxQ.delete();
        end
      end
      if (eRdy)
        for (int j = 0; j < SER_W; j++) begin
          for (int l = 0; l < LANES; l++) e[l] = link.TXD_VALID_I & link.TXD_I[l*SER_W+j];
          txQ.push_back(e);
        end
      if (!en) begin
        mSt = M_OFF;
        biasCnt = 0;
        txQ.delete();
        rxQ.delete();
      end else if (mSt == M_OFF) begin
        mSt = M_BIAS;
        biasCnt = 0;
      end else if (mSt == M_BIAS) begin
        biasCnt++;
        if (biasCnt == BIAS_WAIT) mSt = M_IDLE;
      end else if (mSt == M_IDLE) begin
        if (!link.EI_REQ_I) mSt = M_ACT;
      end else if (slot && stop) mSt = M_IDLE;
      eiPend = mSt == M_ACT && stop;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic newWords();
    for (int l = 0; l < LANES; l++) link.TXD_I[l*SER_W +: SER_W] = SER_W'($urandom);
  endtask
  initial begin
    bit pat[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    resetModel();
    link.EN_I = 0;
    link.EI_REQ_I = 1;
    link.TXD_VALID_I = 0;
    link.TXD_I = '0;
    link.TX_POL_I = '0;
    link.RX_POL_I = '0;
    padDi = '0;
    padEiDet = '0;
    loop = 0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) step();
    rst = 0;
    link.EN_I = 1;
    repeat (24) step();
    loop = 1;
    link.EI_REQ_I = 0;
    link.TXD_VALID_I = 1;
    newWords();
    link.TXD_I[SER_W-1:0] = 8'hA5;
    repeat (20) step();
    link.TX_POL_I = 4'b0010;
    link.RX_POL_I = 4'b0010;
    for (int i = 0; i < 20; i++) begin newWords(); step(); end
    link.TX_POL_I = '0;
    link.RX_POL_I = '0;
    link.TXD_VALID_I = 0;
    repeat (9) step();
    link.TXD_VALID_I = 1;
    repeat (20) step();
    repeat (3) step();
    link.EI_REQ_I = 1;
    repeat (12) step();
    link.EI_REQ_I = 0;
    repeat (6) step();
    foreach (pat[i]) begin padEiDet[2] = pat[i]; step(); end
    repeat (3) step();
    padEiDet = '0;
    repeat (5) step();
    link.EN_I = 0;
    step();
    link.EN_I = 1;
    repeat (3) step();
    for (int c = 0; c < 6000; c++) begin
      rst = $urandom_range(0, 1999) == 0;
      link.EN_I = $urandom_range(0, 299) != 0;
      if ($urandom_range(0, 39) == 0) link.EI_REQ_I = ~link.EI_REQ_I;
      link.TXD_VALID_I = $urandom_range(0, 5) != 0;
      newWords();
      if ($urandom_range(0, 63) == 0) link.TX_POL_I = LANES'($urandom);
      if ($urandom_range(0, 63) == 0) link.RX_POL_I = LANES'($urandom);
      for (int l = 0; l < LANES; l++) padEiDet[l] = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 99) == 0) loop = ~loop;
      if (!loop) padDi = LANES'($urandom);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/hplvds_lane_ctrl.md
Name: hplvds_lane_ctrl

Overview:
- Multi-lane controller for the HPLVDS TX/RX pad cell. Sits between the link-layer datapath and N pad instances.
- Sequences pad power-up: bias, VCM, termination and electrical idle.
- Serialises parallel TX words and deserialises RX bits, LSB first, one bit per clock per lane.
- Applies per-lane polarity and debounces the pads' EI-detect outputs. Pad TX_POL_I and RX_POL_I are tied low; all polarity handling happens in this block.

Parameters:
- LANES, 4, number of pad lanes (1..16)
- SER_W, 8, bits per word per lane (2..32)
- BIAS_WAIT, 16, cycles held in BIAS state before idle (>=1)
- EI_DEB, 4, consecutive cycles of EI-detect high required to report idle (>=1)

Ports:
- CLK_I  in  1  sole clock
- RST_I  in  1  synchronous active-high reset
- EN_I  in  1  link enable
- EI_REQ_I  in  1  request transmit electrical idle
- TXD_I  in  LANES*SER_W  TX word; lane l occupies [l*SER_W +: SER_W]
- TXD_VALID_I  in  1  TX word valid
- TXD_READY_O  out  1  TX word accepted when VALID&READY
- TX_POL_I  in  LANES  per-lane TX inversion
- RX_POL_I  in  LANES  per-lane RX inversion
- RXD_O  out  LANES*SER_W  RX word
- RXD_VALID_O  out  1  one-cycle pulse per RX word
- UNDERFLOW_O  out  1  one-cycle pulse when a word slot had no valid data
- STATE_O  out  2  0=OFF 1=BIAS 2=IDLE 3=ACTIVE
- EI_DETECTED_O  out  LANES  debounced per-lane EI indication
- PAD_DO_O  out  LANES  to pad DO_I
- PAD_TX_EN_O  out  1  to pad TX_EN_I
- PAD_TX_VCM_EN_O  out  1  to pad TX_VCM_EN_I
- PAD_TX_EI_O  out  1  to pad TX_EI_I
- PAD_RTERM_EN_O  out  1  to pad RTERM_EN_I
- PAD_EI_DET_EN_O  out  1  to pad EI_DETECT_EN_I
- PAD_DI_I  in  LANES  from pad DI_O
- PAD_EI_DET_I  in  LANES  from pad EI_DETECT_O

Behaviour:
- Reset: state OFF; all outputs 0; bit counter and shift registers 0; debounce counters 0.
- OFF:
  - All PAD_* controls are 0.
  - Moves to BIAS when EN_I=1.
- BIAS:
  - PAD_TX_EN, PAD_TX_VCM_EN, PAD_RTERM_EN and PAD_TX_EI are 1.
  - Counter runs 0..BIAS_WAIT-1, then the block enters IDLE. BIAS lasts exactly BIAS_WAIT cycles.
- IDLE:
  - PAD_TX_EI=1 and PAD_EI_DET_EN=1.
  - Moves to ACTIVE on the cycle after EI_REQ_I=0 is sampled.
- ACTIVE:
  - PAD_TX_EI=0 and PAD_EI_DET_EN=1.
  - Bit counter cycles 0..SER_W-1.
  - TXD_READY_O=1 only while the counter equals SER_W-1, and on the first ACTIVE cycle (load slot).
  - At a load slot:
    - With VALID=1: the word loads, and bit0 appears on PAD_DO_O on the next cycle.
    - With VALID=0: an all-zero word loads and UNDERFLOW_O pulses.
- EI_REQ_I=1 in ACTIVE: the current word completes, and the block enters IDLE after bit SER_W-1. No new word is accepted at that boundary, and UNDERFLOW_O does not pulse.
- EN_I=0 in any state: OFF next cycle. Any partial TX/RX word is discarded and RXD_VALID is not pulsed.
- PAD_DO_O[l] = shift[l][0] ^ TX_POL_I[l]. Outside ACTIVE, PAD_DO_O = 0.
- RX deserialiser:
  - Runs only in ACTIVE, sampling PAD_DI_I[l] ^ RX_POL_I[l] into bit position = counter.
  - When counter = SER_W-1, RXD_O updates and RXD_VALID_O pulses the following cycle.
  - RXD_O holds its value between pulses.
- EI debounce, per lane:
  - The counter increments while PAD_EI_DET_I[l]=1, saturating at EI_DEB.
  - The counter clears on any 0 and whenever PAD_EI_DET_EN_O=0.
  - EI_DETECTED_O[l] = (count==EI_DEB), registered.
- Polarity inputs are sampled every cycle; a change takes effect mid-word with no protection.
- Reset mid-word: applies at the next edge as the reset row above; no flush.

Decomposition:
- Package hplvds_pkg: state enum (OFF, BIAS, IDLE, ACTIVE) and its 2-bit encoding; the STATE_O mapping.
- Sub-module hplvds_lane: per-lane TX shift register, RX collector and EI debouncer. Instantiated LANES times via generate.
- Top level keeps the FSM, bit counter and handshake.

Test Plan:
- Power-up: RST_I then EN_I=1, LANES=4, BIAS_WAIT=16 -> STATE_O=1 for exactly 16 cycles, then 2; PAD_TX_EI_O=1 throughout.
- Data, lane 0: EI_REQ_I=0, TXD_I lane0=8'hA5, TX_POL=0 -> PAD_DO_O[0] sequence 1,0,1,0,0,1,0,1 from the cycle after acceptance. Loop PAD_DO_O into PAD_DI_I -> RXD_O lane0=8'hA5 with a RXD_VALID_O pulse.
- Polarity: TX_POL_I=4'b0010, RX_POL_I=4'b0010 in loopback -> lane1 recovers its word; PAD_DO_O[1] is the inverse of the unpolarised bitstream.
- Underflow: VALID=0 at a load slot -> UNDERFLOW_O pulses once and PAD_DO_O=0 for 8 cycles; the next valid word transmits normally.
- EI entry: EI_REQ_I=1 at bit 3 -> bits 4..7 complete, STATE_O=2 after bit 7, no READY pulse. EN_I=0 mid-word -> STATE_O=0 next cycle and no RXD_VALID_O.
- Debounce, EI_DEB=4: PAD_EI_DET_I[2] pattern 1,1,1,0,1,1,1,1 -> EI_DETECTED_O[2] asserts only one cycle after the 4th consecutive 1.
